// File: rtl/oup_ulpi_phy_regfile.sv
// oup_ulpi_phy_regfile
// PHY-side ULPI register responder. It decodes RegWrite/RegRead TX CMDs,
// runs the nxt/dir/stp handshakes and holds the immediate-address register
// file, including set/clear aliases, the interrupt latch and the self-clearing
// reset bit.
module oup_ulpi_phy_regfile #(
  parameter logic [15:0] VID = 16'h1D50,
  parameter logic [15:0] PID = 16'h6190
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ulpi_data_i,
  input  logic       ulpi_stp,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe,
  output logic       ulpi_dir,
  output logic       ulpi_nxt,
  input  logic [4:0] int_status_i,
  input  logic [1:0] line_state_i,
  output logic [7:0] function_ctrl_o,
  output logic [7:0] interface_ctrl_o,
  output logic [7:0] otg_ctrl_o,
  output logic       phy_reset_o
);

  typedef enum logic [2:0] {
    IDLE, WR_CMD, WR_DATA, WR_STP, RD_CMD, RD_TA1, RD_DATA, RD_TA2
  } stateType;

  // Writable register selected by the current address, plus the alias operation
  localparam logic [2:0] TGT_FUNC = 3'd0;
  localparam logic [2:0] TGT_IFC  = 3'd1;
  localparam logic [2:0] TGT_OTG  = 3'd2;
  localparam logic [2:0] TGT_RISE = 3'd3;
  localparam logic [2:0] TGT_FALL = 3'd4;
  localparam logic [2:0] TGT_SCR  = 3'd5;
  localparam logic [2:0] TGT_NONE = 3'd7;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_SET   = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;

  stateType   r_state;
  logic [5:0] r_addr;
  logic [7:0] r_wrData;
  logic [7:0] r_dataOut;
  logic       r_dataOe;
  logic       r_dir;
  logic       r_nxt;
  logic       r_phyReset;
  logic [7:0] r_funcCtrl;
  logic [7:0] r_ifCtrl;
  logic [7:0] r_otgCtrl;
  logic [4:0] r_intEnRise;
  logic [4:0] r_intEnFall;
  logic [7:0] r_scratch;
  logic [4:0] r_intLatch;
  logic [4:0] r_intPrev;

  logic [2:0] w_tgt;
  logic [1:0] w_op;
  logic [7:0] w_cur;
  logic [7:0] w_new;
  logic [7:0] w_rdData;
  logic       w_commit;
  logic       w_latchClr;
  logic [4:0] w_intEdge;

  assign w_commit   = (r_state == WR_STP) && ulpi_stp;
  assign w_latchClr = (r_state == RD_TA1) && (r_addr == 6'h14);
  assign w_intEdge  = (int_status_i & ~r_intPrev & r_intEnRise) |
                      (~int_status_i & r_intPrev & r_intEnFall);

  // Map an address onto its writable register and write/set/clear alias
  always_comb begin
    w_tgt = TGT_NONE;
    w_op  = OP_WRITE;
    case (r_addr)
      6'h04: begin w_tgt = TGT_FUNC; w_op = OP_WRITE; end
      6'h05: begin w_tgt = TGT_FUNC; w_op = OP_SET;   end
      6'h06: begin w_tgt = TGT_FUNC; w_op = OP_CLEAR; end
      6'h07: begin w_tgt = TGT_IFC;  w_op = OP_WRITE; end
      6'h08: begin w_tgt = TGT_IFC;  w_op = OP_SET;   end
      6'h09: begin w_tgt = TGT_IFC;  w_op = OP_CLEAR; end
      6'h0A: begin w_tgt = TGT_OTG;  w_op = OP_WRITE; end
      6'h0B: begin w_tgt = TGT_OTG;  w_op = OP_SET;   end
      6'h0C: begin w_tgt = TGT_OTG;  w_op = OP_CLEAR; end
      6'h0D: begin w_tgt = TGT_RISE; w_op = OP_WRITE; end
      6'h0E: begin w_tgt = TGT_RISE; w_op = OP_SET;   end
      6'h0F: begin w_tgt = TGT_RISE; w_op = OP_CLEAR; end
      6'h10: begin w_tgt = TGT_FALL; w_op = OP_WRITE; end
      6'h11: begin w_tgt = TGT_FALL; w_op = OP_SET;   end
      6'h12: begin w_tgt = TGT_FALL; w_op = OP_CLEAR; end
      6'h16: begin w_tgt = TGT_SCR;  w_op = OP_WRITE; end
      6'h17: begin w_tgt = TGT_SCR;  w_op = OP_SET;   end
      6'h18: begin w_tgt = TGT_SCR;  w_op = OP_CLEAR; end
      default: begin w_tgt = TGT_NONE; w_op = OP_WRITE; end
    endcase
  end

  // Current contents of the selected writable register (unused bits read 0)
  always_comb begin
    w_cur = 8'h00;
    case (w_tgt)
      TGT_FUNC: w_cur = r_funcCtrl;
      TGT_IFC:  w_cur = r_ifCtrl;
      TGT_OTG:  w_cur = r_otgCtrl;
      TGT_RISE: w_cur = {3'b000, r_intEnRise};
      TGT_FALL: w_cur = {3'b000, r_intEnFall};
      TGT_SCR:  w_cur = r_scratch;
      default:  w_cur = 8'h00;
    endcase
  end

  // Value the selected register takes if the pending write commits
  always_comb begin
    w_new = w_cur;
    case (w_op)
      OP_WRITE: w_new = r_wrData;
      OP_SET:   w_new = w_cur | r_wrData;
      OP_CLEAR: w_new = w_cur & ~r_wrData;
      default:  w_new = w_cur;
    endcase
  end

  // Read data mux; anything without a register behind it reads as zero
  always_comb begin
    w_rdData = 8'h00;
    if (w_tgt != TGT_NONE) begin
      w_rdData = w_cur;
    end else begin
      case (r_addr)
        6'h00:   w_rdData = VID[7:0];
        6'h01:   w_rdData = VID[15:8];
        6'h02:   w_rdData = PID[7:0];
        6'h03:   w_rdData = PID[15:8];
        6'h13:   w_rdData = {3'b000, int_status_i};
        6'h14:   w_rdData = {3'b000, r_intLatch};
        6'h15:   w_rdData = {6'b000000, line_state_i};
        default: w_rdData = 8'h00;
      endcase
    end
  end

  // Bus handshake FSM with registered pin outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= 6'h00;
      r_wrData  <= 8'h00;
      r_dataOut <= 8'h00;
      r_dataOe  <= 1'b0;
      r_dir     <= 1'b0;
      r_nxt     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ulpi_data_i[7:6] == 2'b10) begin
            r_state <= WR_CMD;
            r_addr  <= ulpi_data_i[5:0];
            r_nxt   <= 1'b1;
          end else if (ulpi_data_i[7:6] == 2'b11) begin
            r_state <= RD_CMD;
            r_addr  <= ulpi_data_i[5:0];
            r_nxt   <= 1'b1;
          end
        end
        WR_CMD: begin
          if (ulpi_stp) begin
            r_state <= IDLE;
            r_nxt   <= 1'b0;
          end else begin
            r_state <= WR_DATA;
            r_nxt   <= 1'b1;
          end
        end
        WR_DATA: begin
          r_nxt <= 1'b0;
          if (ulpi_stp) begin
            r_state <= IDLE;
          end else begin
            r_state  <= WR_STP;
            r_wrData <= ulpi_data_i;
          end
        end
        WR_STP: begin
          if (ulpi_stp) begin
            r_state <= IDLE;
          end
        end
        RD_CMD: begin
          r_state  <= RD_TA1;
          r_nxt    <= 1'b0;
          r_dir    <= 1'b1;
          r_dataOe <= 1'b0;
        end
        RD_TA1: begin
          r_state   <= RD_DATA;
          r_dataOe  <= 1'b1;
          r_dataOut <= w_rdData;
        end
        RD_DATA: begin
          r_state   <= RD_TA2;
          r_dir     <= 1'b0;
          r_dataOe  <= 1'b0;
          r_dataOut <= 8'h00;
        end
        RD_TA2: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Register file commits, reset-bit pulse and interrupt latch (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_funcCtrl  <= 8'h41;
      r_ifCtrl    <= 8'h00;
      r_otgCtrl   <= 8'h06;
      r_intEnRise <= 5'h1F;
      r_intEnFall <= 5'h1F;
      r_scratch   <= 8'h00;
      r_intLatch  <= 5'h00;
      r_intPrev   <= 5'h00;
      r_phyReset  <= 1'b0;
    end else begin
      r_phyReset <= 1'b0;
      r_intPrev  <= int_status_i;
      r_intLatch <= (w_latchClr ? 5'h00 : r_intLatch) | w_intEdge;
      if (w_commit) begin
        case (w_tgt)
          TGT_FUNC: begin
            r_funcCtrl <= w_new & 8'hDF;
            r_phyReset <= (w_op != OP_CLEAR) && r_wrData[5];
          end
          TGT_IFC:  r_ifCtrl    <= w_new;
          TGT_OTG:  r_otgCtrl   <= w_new;
          TGT_RISE: r_intEnRise <= w_new[4:0];
          TGT_FALL: r_intEnFall <= w_new[4:0];
          TGT_SCR:  r_scratch   <= w_new;
          default:  r_scratch   <= r_scratch;
        endcase
      end
    end
  end

  assign ulpi_data_o      = r_dataOut;
  assign ulpi_data_oe     = r_dataOe;
  assign ulpi_dir         = r_dir;
  assign ulpi_nxt         = r_nxt;
  assign function_ctrl_o  = r_funcCtrl;
  assign interface_ctrl_o = r_ifCtrl;
  assign otg_ctrl_o       = r_otgCtrl;
  assign phy_reset_o      = r_phyReset;

endmodule

// File: tb/tb_oup_ulpi_phy_regfile.sv
// tb_oup_ulpi_phy_regfile
// Self-checking bench: drives ULPI register transactions from the link side,
// queues expected read bytes and compares them when the PHY drives the bus.
module tb_oup_ulpi_phy_regfile;

  logic       clk;
  logic       rst;
  logic [7:0] ulpi_data_i;
  logic       ulpi_stp;
  logic [7:0] ulpi_data_o;
  logic       ulpi_data_oe;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [4:0] int_status_i;
  logic [1:0] line_state_i;
  logic [7:0] function_ctrl_o;
  logic [7:0] interface_ctrl_o;
  logic [7:0] otg_ctrl_o;
  logic       phy_reset_o;

  int checkCount  = 0;
  int errorCount  = 0;
  int resetPulses = 0;
  logic [7:0] expQ[$];
  logic [7:0] expScratch;

  oup_ulpi_phy_regfile dut (
    .clk              (clk),
    .rst              (rst),
    .ulpi_data_i      (ulpi_data_i),
    .ulpi_stp         (ulpi_stp),
    .ulpi_data_o      (ulpi_data_o),
    .ulpi_data_oe     (ulpi_data_oe),
    .ulpi_dir         (ulpi_dir),
    .ulpi_nxt         (ulpi_nxt),
    .int_status_i     (int_status_i),
    .line_state_i     (line_state_i),
    .function_ctrl_o  (function_ctrl_o),
    .interface_ctrl_o (interface_ctrl_o),
    .otg_ctrl_o       (otg_ctrl_o),
    .phy_reset_o      (phy_reset_o)
  );

  // 60 MHz-ish clock; exact period does not matter for the protocol
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every comparison and report mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-data scoreboard: compare whenever the PHY drives the bus
  always @(negedge clk) begin
    if (!rst && ulpi_data_oe) begin
      checkOutput("rd_queue_size", expQ.size(), 1);
      if (expQ.size() > 0) begin
        checkOutput("rd_data", {24'h0, ulpi_data_o}, {24'h0, expQ.pop_front()});
      end
    end
  end

  // Count cycles in which the reset pulse is high
  always @(negedge clk) begin
    if (phy_reset_o) resetPulses++;
  end

  // One link-side register transaction; optional write abort and interrupt poke
  task automatic applyStimulus(input bit isRead, input logic [5:0] addr,
                               input logic [7:0] wdata, input logic [7:0] expRd,
                               input bit abortWr, input bit pokeInt,
                               input logic [4:0] newInt);
    int nxtCount;
    nxtCount = 0;
    if (isRead) begin
      ulpi_data_i = {2'b11, addr};
      expQ.push_back(expRd);
      tick();
      checkOutput("rd_e0_nxt", ulpi_nxt, 1);
      checkOutput("rd_e0_dir", ulpi_dir, 0);
      ulpi_data_i = 8'h00;
      tick();
      checkOutput("rd_e1_dir", ulpi_dir, 1);
      checkOutput("rd_e1_nxt", ulpi_nxt, 0);
      checkOutput("rd_e1_oe", ulpi_data_oe, 0);
      if (pokeInt) int_status_i = newInt;
      tick();
      checkOutput("rd_e2_dir", ulpi_dir, 1);
      checkOutput("rd_e2_oe", ulpi_data_oe, 1);
      tick();
      checkOutput("rd_e3_dir", ulpi_dir, 0);
      checkOutput("rd_e3_oe", ulpi_data_oe, 0);
      checkOutput("rd_e3_data", ulpi_data_o, 0);
      tick();
    end else begin
      ulpi_data_i = {2'b10, addr};
      tick();
      nxtCount += int'(ulpi_nxt);
      ulpi_data_i = wdata;
      tick();
      nxtCount += int'(ulpi_nxt);
      if (abortWr) begin
        ulpi_stp = 1'b1;
        tick();
        ulpi_stp = 1'b0;
        ulpi_data_i = 8'h00;
        checkOutput("abort_nxt", ulpi_nxt, 0);
        checkOutput("abort_dir", ulpi_dir, 0);
      end else begin
        tick();
        nxtCount += int'(ulpi_nxt);
        ulpi_data_i = 8'h00;
        ulpi_stp = 1'b1;
        tick();
        ulpi_stp = 1'b0;
        nxtCount += int'(ulpi_nxt);
        checkOutput("wr_nxt_cycles", nxtCount, 2);
        checkOutput("wr_dir", ulpi_dir, 0);
      end
    end
  endtask

  task automatic readReg(input logic [5:0] addr, input logic [7:0] expRd);
    applyStimulus(1'b1, addr, 8'h00, expRd, 1'b0, 1'b0, 5'h00);
  endtask

  task automatic writeReg(input logic [5:0] addr, input logic [7:0] wdata);
    applyStimulus(1'b0, addr, wdata, 8'h00, 1'b0, 1'b0, 5'h00);
  endtask

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    rst = 1'b1;
    ulpi_data_i = 8'h00;
    ulpi_stp = 1'b0;
    int_status_i = 5'h00;
    line_state_i = 2'b00;
    tick();
    tick();
    checkOutput("rst_dir", ulpi_dir, 0);
    checkOutput("rst_nxt", ulpi_nxt, 0);
    checkOutput("rst_oe", ulpi_data_oe, 0);
    checkOutput("rst_data", ulpi_data_o, 0);
    checkOutput("rst_phy_reset", phy_reset_o, 0);
    checkOutput("rst_func", function_ctrl_o, 8'h41);
    checkOutput("rst_ifc", interface_ctrl_o, 8'h00);
    checkOutput("rst_otg", otg_ctrl_o, 8'h06);
    rst = 1'b0;
    tick();

    $display("[TB] identification and reset-value reads");
    readReg(6'h04, 8'h41);
    readReg(6'h00, 8'h50);
    readReg(6'h01, 8'h1D);
    readReg(6'h02, 8'h90);
    readReg(6'h03, 8'h61);

    $display("[TB] scratch write/set/clear aliases");
    expScratch = 8'hA5;
    writeReg(6'h16, 8'hA5);
    expScratch = expScratch | 8'h0A;
    writeReg(6'h17, 8'h0A);
    expScratch = expScratch & ~8'h21;
    writeReg(6'h18, 8'h21);
    readReg(6'h16, expScratch);
    readReg(6'h18, expScratch);

    $display("[TB] self-clearing reset bit");
    writeReg(6'h05, 8'h20);
    checkOutput("phy_reset_high", phy_reset_o, 1);
    checkOutput("func_after_set", function_ctrl_o, 8'h41);
    tick();
    checkOutput("phy_reset_low", phy_reset_o, 0);
    tick();
    checkOutput("phy_reset_cycles", resetPulses, 1);
    readReg(6'h04, 8'h41);
    writeReg(6'h06, 8'h21);
    tick();
    checkOutput("func_after_clear", function_ctrl_o, 8'h40);
    checkOutput("no_pulse_on_clear", resetPulses, 1);

    $display("[TB] interrupt latch");
    int_status_i = 5'b00001;
    tick();
    tick();
    readReg(6'h14, 8'h01);
    readReg(6'h14, 8'h00);
    applyStimulus(1'b1, 6'h14, 8'h00, 8'h00, 1'b0, 1'b1, 5'b00011);
    readReg(6'h14, 8'h02);
    readReg(6'h14, 8'h00);
    readReg(6'h13, 8'h03);

    $display("[TB] aborted write");
    applyStimulus(1'b0, 6'h0A, 8'h55, 8'h00, 1'b1, 1'b0, 5'h00);
    tick();
    checkOutput("otg_after_abort", otg_ctrl_o, 8'h06);
    readReg(6'h0A, 8'h06);

    $display("[TB] read-only and unimplemented addresses");
    writeReg(6'h2F, 8'hFF);
    writeReg(6'h00, 8'h12);
    writeReg(6'h14, 8'h1F);
    readReg(6'h2F, 8'h00);
    readReg(6'h3F, 8'h00);
    readReg(6'h00, 8'h50);
    checkOutput("otg_unchanged", otg_ctrl_o, 8'h06);
    checkOutput("func_unchanged", function_ctrl_o, 8'h40);
    checkOutput("ifc_unchanged", interface_ctrl_o, 8'h00);

    $display("[TB] enable width and debug");
    writeReg(6'h0D, 8'hE4);
    readReg(6'h0D, 8'h04);
    line_state_i = 2'b10;
    readReg(6'h15, 8'h02);

    $display("[TB] reset during read data phase");
    ulpi_data_i = {2'b11, 6'h16};
    tick();
    ulpi_data_i = 8'h00;
    tick();
    tick();
    checkOutput("pre_rst_oe", ulpi_data_oe, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_dir", ulpi_dir, 0);
    checkOutput("mid_rst_oe", ulpi_data_oe, 0);
    checkOutput("mid_rst_nxt", ulpi_nxt, 0);
    tick();
    rst = 1'b0;
    tick();
    writeReg(6'h07, 8'h02);
    checkOutput("ifc_after_reset", interface_ctrl_o, 8'h02);
    checkOutput("func_after_reset", function_ctrl_o, 8'h41);
    readReg(6'h08, 8'h02);
    readReg(6'h16, 8'h00);

    tick();
    checkOutput("queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
